// File: rtl/schedule_issue_queue.sv
// Issue queue between schedule_1st and execute: FIFO with a first-word-fall-through head.
// Define SCHEDULE_ISSUE_QUEUE_BYPASS_EN to forward input straight to issue when empty.
module schedule_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    output logic        STALL,
    input  logic        SCHEDULE_1ST_VALID,
    input  logic [31:0] SCHEDULE_1ST_PC,
    input  logic [6:0]  SCHEDULE_1ST_OPCODE,
    input  logic [4:0]  SCHEDULE_1ST_RD,
    input  logic [2:0]  SCHEDULE_1ST_FUNCT3,
    input  logic [6:0]  SCHEDULE_1ST_FUNCT7,
    input  logic [31:0] SCHEDULE_1ST_IMM,
    input  logic        ISSUE_READY,
    output logic        ISSUE_VALID,
    output logic [31:0] ISSUE_PC,
    output logic [6:0]  ISSUE_OPCODE,
    output logic [4:0]  ISSUE_RD,
    output logic [2:0]  ISSUE_FUNCT3,
    output logic [6:0]  ISSUE_FUNCT7,
    output logic [31:0] ISSUE_IMM
);

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } op_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    op_t              mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    op_t  in_op;
    op_t  head_op;
    op_t  issue_op;
    logic empty;
    logic push;
    logic pop_q;
    logic take;
    logic wr_en;

    assign in_op = {SCHEDULE_1ST_PC, SCHEDULE_1ST_OPCODE, SCHEDULE_1ST_RD,
                    SCHEDULE_1ST_FUNCT3, SCHEDULE_1ST_FUNCT7, SCHEDULE_1ST_IMM};
    assign head_op = mem[rd_ptr];

    // STALL depends only on registered occupancy, never on ISSUE_READY
    assign empty = (count == '0);
    assign STALL = (count == FULL_CNT);
    assign push  = SCHEDULE_1ST_VALID & ~STALL & ~FLUSH;
    assign pop_q = ~empty & ISSUE_READY & ~FLUSH;

`ifdef SCHEDULE_ISSUE_QUEUE_BYPASS_EN
    logic fwd;
    assign fwd         = empty & SCHEDULE_1ST_VALID & ~FLUSH;
    assign take        = fwd & ISSUE_READY;
    assign ISSUE_VALID = ~empty | fwd;
    assign issue_op    = fwd ? in_op : head_op;
`else
    assign take        = 1'b0;
    assign ISSUE_VALID = ~empty;
    assign issue_op    = head_op;
`endif

    // a forwarded op consumed this cycle never lands in storage
    assign wr_en = push & ~take;

    assign ISSUE_PC     = issue_op.pc;
    assign ISSUE_OPCODE = issue_op.opcode;
    assign ISSUE_RD     = issue_op.rd;
    assign ISSUE_FUNCT3 = issue_op.funct3;
    assign ISSUE_FUNCT7 = issue_op.funct7;
    assign ISSUE_IMM    = issue_op.imm;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= in_op;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop_q})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_schedule_issue_queue.sv
// Bench for schedule_issue_queue: scoreboard of accepted ops checked at issue,
// plus per-scenario checks of reset, stall, flush, wrap and bubble handling.
module tb_schedule_issue_queue;

    localparam int DEPTH = 4;
`ifdef SCHEDULE_ISSUE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        FLUSH;
    logic        STALL;
    logic        SCHEDULE_1ST_VALID;
    logic [31:0] SCHEDULE_1ST_PC;
    logic [6:0]  SCHEDULE_1ST_OPCODE;
    logic [4:0]  SCHEDULE_1ST_RD;
    logic [2:0]  SCHEDULE_1ST_FUNCT3;
    logic [6:0]  SCHEDULE_1ST_FUNCT7;
    logic [31:0] SCHEDULE_1ST_IMM;
    logic        ISSUE_READY;
    logic        ISSUE_VALID;
    logic [31:0] ISSUE_PC;
    logic [6:0]  ISSUE_OPCODE;
    logic [4:0]  ISSUE_RD;
    logic [2:0]  ISSUE_FUNCT3;
    logic [6:0]  ISSUE_FUNCT7;
    logic [31:0] ISSUE_IMM;

    schedule_issue_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .CLK                (CLK),
        .RST                (RST),
        .FLUSH              (FLUSH),
        .STALL              (STALL),
        .SCHEDULE_1ST_VALID (SCHEDULE_1ST_VALID),
        .SCHEDULE_1ST_PC    (SCHEDULE_1ST_PC),
        .SCHEDULE_1ST_OPCODE(SCHEDULE_1ST_OPCODE),
        .SCHEDULE_1ST_RD    (SCHEDULE_1ST_RD),
        .SCHEDULE_1ST_FUNCT3(SCHEDULE_1ST_FUNCT3),
        .SCHEDULE_1ST_FUNCT7(SCHEDULE_1ST_FUNCT7),
        .SCHEDULE_1ST_IMM   (SCHEDULE_1ST_IMM),
        .ISSUE_READY        (ISSUE_READY),
        .ISSUE_VALID        (ISSUE_VALID),
        .ISSUE_PC           (ISSUE_PC),
        .ISSUE_OPCODE       (ISSUE_OPCODE),
        .ISSUE_RD           (ISSUE_RD),
        .ISSUE_FUNCT3       (ISSUE_FUNCT3),
        .ISSUE_FUNCT7       (ISSUE_FUNCT7),
        .ISSUE_IMM          (ISSUE_IMM)
    );

    int vectors = 0;
    int miscompares = 0;
    int issued = 0;
    logic [85:0] sb[$];
    logic [85:0] mon_got;
    logic [85:0] mon_exp;
    logic        mon_ev;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [85:0] op_of(input logic [31:0] pc);
        return {pc, pc[8:2], pc[6:2] ^ 5'h15, pc[4:2] ^ 3'h5, pc[10:4], ~pc};
    endfunction

    function automatic logic [85:0] issue_bus();
        return {ISSUE_PC, ISSUE_OPCODE, ISSUE_RD, ISSUE_FUNCT3, ISSUE_FUNCT7, ISSUE_IMM};
    endfunction

    task automatic put(input bit v, input logic [31:0] pc);
        SCHEDULE_1ST_VALID = v;
        {SCHEDULE_1ST_PC, SCHEDULE_1ST_OPCODE, SCHEDULE_1ST_RD, SCHEDULE_1ST_FUNCT3,
         SCHEDULE_1ST_FUNCT7, SCHEDULE_1ST_IMM} = v ? op_of(pc) : '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // upstream model: hold each op until STALL is low, bounded in cycles
    task automatic feed(input logic [31:0] base, input int n, output int cyc, output int acc);
        bit ok;
        cyc = 0;
        acc = 0;
        while (acc < n && cyc < 40) begin
            put(1'b1, base + 32'(4 * acc));
            #1;
            ok = !STALL;
            tick(1);
            cyc++;
            if (ok) acc++;
        end
    endtask

    // scoreboard: record accepted ops, compare every issue handshake against the oldest
    always @(negedge CLK) begin
        if (RST) begin
            sb.delete();
        end else begin
            mon_ev = (sb.size() != 0) || (BYP && SCHEDULE_1ST_VALID && !FLUSH);
            vectors++;
            if (ISSUE_VALID !== mon_ev) begin
                miscompares++;
                $display("FAIL mon_issue_valid got %b want %b t=%0t", ISSUE_VALID, mon_ev, $time);
            end
            vectors++;
            if (STALL !== (sb.size() == DEPTH)) begin
                miscompares++;
                $display("FAIL mon_stall got %b want %b t=%0t", STALL, sb.size() == DEPTH, $time);
            end
            if (SCHEDULE_1ST_VALID && sb.size() != DEPTH && !FLUSH) begin
                sb.push_back({SCHEDULE_1ST_PC, SCHEDULE_1ST_OPCODE, SCHEDULE_1ST_RD,
                              SCHEDULE_1ST_FUNCT3, SCHEDULE_1ST_FUNCT7, SCHEDULE_1ST_IMM});
            end
            if (ISSUE_VALID && ISSUE_READY && !FLUSH) begin
                issued++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL mon_spurious_issue got pc %h want none", ISSUE_PC);
                end else begin
                    mon_exp = sb.pop_front();
                    mon_got = issue_bus();
                    if (mon_got !== mon_exp) begin
                        miscompares++;
                        $display("FAIL mon_issue_op got %h want %h", mon_got, mon_exp);
                    end
                end
            end
            if (FLUSH) sb.delete();
        end
    end

    task automatic test_reset();
        RST = 1'b1;
        FLUSH = 1'b0;
        ISSUE_READY = 1'b0;
        put(1'b0, '0);
        #3;
        vectors++;
        if ({ISSUE_VALID, STALL} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00", {ISSUE_VALID, STALL});
        end
        vectors++;
        if (issue_bus() !== 86'd0) begin
            miscompares++;
            $display("FAIL reset_fields got %h want 0", issue_bus());
        end
        tick(2);
        RST = 1'b0;
        tick(1);
        vectors++;
        if (ISSUE_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_valid got %b want 0", ISSUE_VALID);
        end
    endtask

    task automatic test_async_reset();
        ISSUE_READY = 1'b0;
        put(1'b1, 32'h100); tick(1);
        put(1'b1, 32'h104); tick(1);
        put(1'b1, 32'h108); tick(1);
        put(1'b0, '0);
        vectors++;
        if (ISSUE_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre_valid got %b want 1", ISSUE_VALID);
        end
        RST = 1'b1;
        #1;
        vectors++;
        if ({ISSUE_VALID, STALL} !== 2'b00 || ISSUE_PC !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_immediate got v=%b s=%b pc=%h want 0 0 0", ISSUE_VALID, STALL, ISSUE_PC);
        end
        #1;
        RST = 1'b0;
        sb.delete();
        tick(2);
        vectors++;
        if (ISSUE_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_after got %b want 0", ISSUE_VALID);
        end
    endtask

    task automatic test_stream();
        int i0;
        i0 = issued;
        ISSUE_READY = 1'b1;
        put(1'b1, 32'h100);
        #1;
        vectors++;
        if (ISSUE_VALID !== BYP) begin
            miscompares++;
            $display("FAIL stream_latency got %b want %b", ISSUE_VALID, BYP);
        end
        tick(1);
        vectors++;
        if (ISSUE_VALID !== 1'b1 || ISSUE_PC !== 32'h100) begin
            miscompares++;
            $display("FAIL stream_first got v=%b pc=%h want 1 100", ISSUE_VALID, ISSUE_PC);
        end
        put(1'b1, 32'h104); tick(1);
        put(1'b1, 32'h108); tick(1);
        put(1'b0, '0); tick(2);
        vectors++;
        if (issued - i0 !== 3 || ISSUE_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_count got %0d v=%b want 3 0", issued - i0, ISSUE_VALID);
        end
        ISSUE_READY = 1'b0;
    endtask

    task automatic test_full_stall();
        int cyc;
        int acc;
        ISSUE_READY = 1'b0;
        feed(32'h100, 4, cyc, acc);
        vectors++;
        if (acc !== 4 || cyc !== 4 || STALL !== 1'b1) begin
            miscompares++;
            $display("FAIL full_fill got acc=%0d cyc=%0d s=%b want 4 4 1", acc, cyc, STALL);
        end
        put(1'b1, 32'h110);
        tick(2);
        vectors++;
        if (STALL !== 1'b1 || ISSUE_PC !== 32'h100) begin
            miscompares++;
            $display("FAIL full_hold got s=%b pc=%h want 1 100", STALL, ISSUE_PC);
        end
        ISSUE_READY = 1'b1;
        tick(1);
        ISSUE_READY = 1'b0;
        vectors++;
        if (STALL !== 1'b0 || ISSUE_PC !== 32'h104) begin
            miscompares++;
            $display("FAIL full_drain_one got s=%b pc=%h want 0 104", STALL, ISSUE_PC);
        end
        tick(1);
        put(1'b0, '0);
        vectors++;
        if (STALL !== 1'b1) begin
            miscompares++;
            $display("FAIL full_refill got s=%b want 1", STALL);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        int acc;
        int i0;
        i0 = issued;
        ISSUE_READY = 1'b1;
        feed(32'h114, 8, cyc, acc);
        vectors++;
        if (acc !== 8 || cyc !== 9) begin
            miscompares++;
            $display("FAIL wrap_throughput got acc=%0d cyc=%0d want 8 9", acc, cyc);
        end
        put(1'b0, '0);
        tick(6);
        vectors++;
        if (issued - i0 !== 12 || ISSUE_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_drain got %0d v=%b want 12 0", issued - i0, ISSUE_VALID);
        end
        ISSUE_READY = 1'b0;
    endtask

    task automatic test_flush();
        int i0;
        ISSUE_READY = 1'b0;
        put(1'b1, 32'h1F0); tick(1);
        put(1'b1, 32'h1F4); tick(1);
        put(1'b1, 32'h200);
        FLUSH = 1'b1;
        tick(1);
        FLUSH = 1'b0;
        put(1'b0, '0);
        vectors++;
        if ({ISSUE_VALID, STALL} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_state got %b want 00", {ISSUE_VALID, STALL});
        end
        i0 = issued;
        ISSUE_READY = 1'b1;
        tick(3);
        vectors++;
        if (issued - i0 !== 0) begin
            miscompares++;
            $display("FAIL flush_no_issue got %0d want 0", issued - i0);
        end
        ISSUE_READY = 1'b0;
    endtask

    task automatic test_bubbles();
        bit          vld [6] = '{0, 1, 0, 0, 1, 0};
        logic [31:0] pcs [6] = '{32'h0, 32'h300, 32'h0, 32'h0, 32'h308, 32'h0};
        int i0;
        i0 = issued;
        ISSUE_READY = 1'b0;
        for (int k = 0; k < 6; k++) begin
            put(vld[k], pcs[k]);
            tick(1);
        end
        put(1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (ISSUE_VALID !== 1'b1 || issue_bus() !== op_of(32'h300)) begin
                miscompares++;
                $display("FAIL bubble_stable got v=%b op=%h want 1 %h", ISSUE_VALID, issue_bus(), op_of(32'h300));
            end
            tick(1);
        end
        ISSUE_READY = 1'b1;
        tick(4);
        vectors++;
        if (issued - i0 !== 2 || ISSUE_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_count got %0d v=%b want 2 0", issued - i0, ISSUE_VALID);
        end
        ISSUE_READY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_stream();
        test_full_stall();
        test_wrap();
        test_flush();
        test_bubbles();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
